// File: rtl/mdsa_pkg.sv
// Shared definitions for the matrix sort controller: FSM states, default
// geometry/timing values and the phase_sel encoding.
package mdsa_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    localparam int DIM_DEF        = 3;
    localparam int NUM_PHASES_DEF = 3;
    localparam int TIMEOUT_DEF    = 16;

    localparam logic SEL_ROW = 1'b0;
    localparam logic SEL_COL = 1'b1;

endpackage

// File: rtl/mdsa_sat_counter.sv
// Up-counter that clears on request and holds at MAX instead of wrapping;
// tc flags that the terminal value has been reached.
module mdsa_sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == MAX_V);

endmodule

// File: rtl/mdsa_sort_ctrl.sv
// Job sequencer for a DIM x DIM mesh sorter: load elements, run alternating
// row/column sort phases with a watchdog, then stream the result back out.
module mdsa_sort_ctrl
    import mdsa_pkg::*;
#(
    parameter int DIM        = DIM_DEF,
    parameter int NUM_PHASES = NUM_PHASES_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         en,
    input  logic                         phase_done,
    output logic                         rdy,
    output logic                         load_we,
    output logic [$clog2(DIM*DIM)-1:0]   load_addr,
    output logic                         phase_go,
    output logic                         phase_sel,
    output logic                         output_enable,
    output logic [$clog2(DIM*DIM)-1:0]   rd_addr,
    output logic                         err
);

    localparam int N  = DIM * DIM;
    localparam int AW = $clog2(N);
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int TW = $clog2(TIMEOUT);

    state_t        state, state_nx;
    logic [PW-1:0] phase_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          load_tc, phase_tc, rd_tc, tmo_tc_unused;
    logic          accept, done_seen, last_phase, tmo_exp, phase_odd;
    logic          in_wait, in_launch, in_unload;

    assign in_wait    = (state == S_WAIT);
    assign in_launch  = (state == S_LAUNCH);
    assign in_unload  = (state == S_UNLOAD);
    assign accept     = (state == S_IDLE) && start;
    assign load_we    = (state == S_LOAD) && en;
    assign done_seen  = in_wait && phase_done;
    assign last_phase = done_seen && phase_tc;
    assign phase_odd  = (phase_cnt & PW'(1)) != '0;
    // Expiry fires on the edge where the counter would reach TIMEOUT-1; a
    // simultaneous phase_done takes priority.
    assign tmo_exp    = in_wait && !phase_done && (tmo_cnt == TW'(TIMEOUT - 2));

    mdsa_sat_counter #(.W(AW), .MAX(N - 1)) u_load_cnt (
        .clk(clk), .rst(rst), .clr(accept), .inc(load_we),
        .count(load_addr), .tc(load_tc)
    );

    mdsa_sat_counter #(.W(PW), .MAX(NUM_PHASES - 1)) u_phase_cnt (
        .clk(clk), .rst(rst), .clr(accept), .inc(done_seen),
        .count(phase_cnt), .tc(phase_tc)
    );

    mdsa_sat_counter #(.W(TW), .MAX(TIMEOUT - 1)) u_tmo_cnt (
        .clk(clk), .rst(rst), .clr(in_launch), .inc(in_wait),
        .count(tmo_cnt), .tc(tmo_tc_unused)
    );

    mdsa_sat_counter #(.W(AW), .MAX(N - 1)) u_rd_cnt (
        .clk(clk), .rst(rst), .clr(last_phase), .inc(in_unload),
        .count(rd_addr), .tc(rd_tc)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD;
            S_LOAD:   if (en && load_tc) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT: begin
                if (phase_done)   state_nx = phase_tc ? S_UNLOAD : S_LAUNCH;
                else if (tmo_exp) state_nx = S_IDLE;
            end
            S_UNLOAD: if (rd_tc) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up
    // with the cycle the FSM actually occupies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            rdy           <= 1'b1;
            phase_go      <= 1'b0;
            phase_sel     <= SEL_ROW;
            output_enable <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nx;
            rdy           <= (state_nx == S_IDLE);
            phase_go      <= (state_nx == S_LAUNCH);
            output_enable <= (state_nx == S_UNLOAD);
            if (state_nx == S_LAUNCH) begin
                if (state == S_LOAD) phase_sel <= SEL_ROW;
                else                 phase_sel <= phase_odd ? SEL_ROW : SEL_COL;
            end
            if (accept)       err <= 1'b0;
            else if (tmo_exp) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mdsa_sort_ctrl.sv
// Directed and randomized job sequences for mdsa_sort_ctrl, checked cycle by
// cycle against a job-level model of load / phase / unload behaviour.
module tb_mdsa_sort_ctrl;

    localparam int DIM = 3;
    localparam int NP  = 3;
    localparam int TMO = 16;
    localparam int N   = DIM * DIM;
    localparam int AW  = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          en = 1'b0;
    logic          phase_done = 1'b0;
    logic          rdy, load_we, phase_go, phase_sel, output_enable, err;
    logic [AW-1:0] load_addr, rd_addr;

    int   n_chk = 0;
    int   n_pass = 0;
    logic x_rdy, x_we, x_go, x_sel, x_oe, x_err;
    int   x_la, x_rd;
    bit   c_la, c_rd, c_sel;
    logic err_m = 1'b0;

    always #5 clk = ~clk;

    mdsa_sort_ctrl #(.DIM(DIM), .NUM_PHASES(NP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .phase_done(phase_done),
        .rdy(rdy), .load_we(load_we), .load_addr(load_addr),
        .phase_go(phase_go), .phase_sel(phase_sel),
        .output_enable(output_enable), .rd_addr(rd_addr), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rdy", 32'(rdy), 32'(x_rdy));
        chk("load_we", 32'(load_we), 32'(x_we));
        chk("phase_go", 32'(phase_go), 32'(x_go));
        chk("output_enable", 32'(output_enable), 32'(x_oe));
        chk("err", 32'(err), 32'(x_err));
        if (c_la)  chk("load_addr", 32'(load_addr), 32'(x_la));
        if (c_rd)  chk("rd_addr", 32'(rd_addr), 32'(x_rd));
        if (c_sel) chk("phase_sel", 32'(phase_sel), 32'(x_sel));
    endtask

    task automatic exp_idle();
        x_rdy = 1'b1; x_we = 1'b0; x_go = 1'b0; x_oe = 1'b0; x_err = err_m;
        c_la = 1'b0; c_rd = 1'b0; c_sel = 1'b0;
    endtask

    task automatic exp_busy();
        x_rdy = 1'b0; x_we = 1'b0; x_go = 1'b0; x_oe = 1'b0; x_err = 1'b0;
        c_la = 1'b0; c_rd = 1'b0; c_sel = 1'b0;
    endtask

    // Drive one cycle's inputs just after the edge, check mid-cycle.
    task automatic tick(input logic s, input logic e, input logic pd);
        start = s; en = e; phase_done = pd;
        #4;
        check_all();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        exp_idle();
        x_err = 1'b0;
        c_la = 1'b1; x_la = 0;
        c_rd = 1'b1; x_rd = 0;
        c_sel = 1'b1; x_sel = 1'b0;
        check_all();
    endtask

    task automatic rnd_bit(input bit active, output logic b);
        b = active ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // mode 0: en always high, phase_done 4 cycles after phase_go
    // mode 1: en pattern 1,0,1,1,0 repeating, random phase latency
    // mode 2: random en and random phase latency
    task automatic run_job(input int mode, input int tmo_ph, input int race_ph,
                           input int abort_ph, input bit busy, input bit noise);
        bit   pat[5];
        int   writes, cyc, d;
        logic e, pd, s;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        exp_idle();
        rnd_bit(noise, e);
        rnd_bit(noise, pd);
        tick(1'b1, e, pd);
        err_m = 1'b0;

        writes = 0;
        cyc = 0;
        while (writes < N) begin
            case (mode)
                0:       e = 1'b1;
                1:       e = pat[cyc % 5];
                default: e = (cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            exp_busy();
            x_we = e; c_la = 1'b1; x_la = writes;
            rnd_bit(noise, pd);
            tick(busy, e, pd);
            if (e) writes++;
            cyc++;
        end

        for (int p = 0; p < NP; p++) begin
            exp_busy();
            x_go = 1'b1; c_sel = 1'b1; x_sel = ((p % 2) == 1);
            rnd_bit(noise, e);
            rnd_bit(noise, pd);
            tick(1'b0, e, pd);
            if (p == tmo_ph)       d = 0;
            else if (p == race_ph) d = TMO - 1;
            else if (mode == 0)    d = 4;
            else                   d = $urandom_range(1, TMO - 1);
            for (int k = 1; k < TMO; k++) begin
                exp_busy();
                c_sel = 1'b1; x_sel = ((p % 2) == 1);
                if (p == abort_ph && k == 3) begin
                    start = 1'b0; en = 1'b0; phase_done = 1'b0;
                    rst = 1'b1;
                    #1;
                    err_m = 1'b0;
                    check_reset_values();
                    @(posedge clk);
                    @(posedge clk);
                    #1;
                    check_reset_values();
                    rst = 1'b0;
                    return;
                end
                rnd_bit(noise, e);
                tick(1'b0, e, (k == d));
                if (k == d) break;
            end
            if (d == 0) begin
                err_m = 1'b1;
                exp_idle();
                tick(1'b0, 1'b0, 1'b0);
                exp_idle();
                tick(1'b0, 1'b1, 1'b1);
                return;
            end
        end

        for (int i = 0; i < N; i++) begin
            exp_busy();
            x_oe = 1'b1; c_rd = 1'b1; x_rd = i;
            s = busy && (i == N - 1);
            rnd_bit(noise, e);
            rnd_bit(noise, pd);
            tick(s, e, pd);
        end
        exp_idle();
        tick(1'b0, 1'b0, 1'b0);
        exp_idle();
        tick(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int tp, rp;
        #1 rst = 1'b1;
        #1 check_reset_values();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        run_job(0, -1, -1, -1, 1'b0, 1'b0);   // nominal
        run_job(1, -1, -1, -1, 1'b0, 1'b0);   // load stalls
        run_job(0,  0, -1, -1, 1'b0, 1'b0);   // timeout on first phase
        run_job(0, -1,  1, -1, 1'b0, 1'b0);   // done coincides with expiry
        run_job(0, -1, -1,  1, 1'b0, 1'b0);   // reset during second phase
        run_job(0, -1, -1, -1, 1'b0, 1'b0);   // clean run after abort
        run_job(0, -1, -1, -1, 1'b1, 1'b0);   // start while busy
        for (int j = 0; j < 8; j++) begin
            tp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
            rp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
            run_job(2, tp, rp, -1, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
